// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
// Frame layout on the line: SYNC_WORD (MSB first), slots a..d, even parity bit.
package tdm_pkg;

  localparam int unsigned SYNC_LEN  = 4;
  localparam int unsigned N_SLOTS   = 4;
  localparam int unsigned FRAME_LEN = SYNC_LEN + N_SLOTS + 1;

  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1110;

  typedef enum logic [1:0] {
    StHunt,
    StData,
    StParity,
    StSync
  } state_e;

  // Header bit expected at position idx of the header; position 0 is the MSB.
  function automatic logic sync_bit(logic [SYNC_LEN-1:0] word, logic [1:0] idx);
    logic [1:0] pos;
    pos = 2'd3 - idx;
    return word[pos];
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer.
// The slave side is the demux; the master side drives the line and watches the channels.
interface tdm_demux4_if;
  import tdm_pkg::*;

  logic                       en;
  logic                       din;
  logic                       a;
  logic                       b;
  logic                       c;
  logic                       d;
  logic [$clog2(N_SLOTS)-1:0] sel;
  logic                       valid;
  logic                       locked;
  logic                       par_err;
  logic                       sync_err;

  modport master (
    output en,
    output din,
    input  a,
    input  b,
    input  c,
    input  d,
    input  sel,
    input  valid,
    input  locked,
    input  par_err,
    input  sync_err
  );

  modport slave (
    input  en,
    input  din,
    output a,
    output b,
    output c,
    output d,
    output sel,
    output valid,
    output locked,
    output par_err,
    output sync_err
  );

endinterface

// File: rtl/tdm_sync_det.sv
// Header hunter: shift register of accepted bits plus comparator against the sync word.
// match looks at the register including the bit being accepted this cycle.
module tdm_sync_det
  import tdm_pkg::*;
#(
  parameter logic [SYNC_LEN-1:0] SyncWord = SYNC_WORD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  input  logic clr,
  output logic match
);

  logic [SYNC_LEN-1:0] sr_q;
  logic [SYNC_LEN-1:0] sr_d;
  logic [SYNC_LEN-1:0] shifted;

  always_comb begin
    shifted = {sr_q[SYNC_LEN-2:0], din};
    sr_d    = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d = shifted;
    end
    match = en && !clr && (shifted == SyncWord);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: finds frame sync, routes slots to channel registers,
// checks even parity and holds alignment by position while locked.
module tdm_demux4
  import tdm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  state_e              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic [1:0]          hdr_q, hdr_d;
  logic [N_SLOTS-1:0]  shadow_q, shadow_d;
  logic [N_SLOTS-1:0]  chan_q, chan_d;
  logic                locked_q, locked_d;
  logic                valid_q, valid_d;
  logic                par_err_q, par_err_d;
  logic                sync_err_q, sync_err_d;
  logic                hunt_match;
  logic                parity_ok;

  // Shift register only accumulates while hunting, so HUNT always starts from a clean slate.
  tdm_sync_det #(
    .SyncWord (SYNC_WORD)
  ) u_sync_det (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .din   (bus.din),
    .clr   (state_q != StHunt),
    .match (hunt_match)
  );

  assign parity_ok = ~(^shadow_q ^ bus.din);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    hdr_d      = hdr_q;
    shadow_d   = shadow_q;
    chan_d     = chan_q;
    locked_d   = locked_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    sync_err_d = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        StHunt: begin
          if (hunt_match) begin
            state_d = StData;
            slot_d  = 2'd0;
          end
        end
        StData: begin
          shadow_d[slot_q] = bus.din;
          slot_d           = slot_q + 2'd1;
          if (slot_q == 2'(N_SLOTS - 1)) begin
            state_d = StParity;
          end
        end
        StParity: begin
          if (parity_ok) begin
            chan_d   = shadow_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            hdr_d    = 2'd0;
            state_d  = StSync;
          end else begin
            par_err_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = StHunt;
          end
        end
        StSync: begin
          if (bus.din == sync_bit(SYNC_WORD, hdr_q)) begin
            if (hdr_q == 2'(SYNC_LEN - 1)) begin
              hdr_d   = 2'd0;
              slot_d  = 2'd0;
              state_d = StData;
            end else begin
              hdr_d = hdr_q + 2'd1;
            end
          end else begin
            // Bits seen after a broken header are dropped, not replayed into the hunter.
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
            hdr_d      = 2'd0;
            state_d    = StHunt;
          end
        end
        default: begin
          state_d = StHunt;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      slot_q     <= 2'd0;
      hdr_q      <= 2'd0;
      shadow_q   <= '0;
      chan_q     <= '0;
      locked_q   <= 1'b0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      hdr_q      <= hdr_d;
      shadow_q   <= shadow_d;
      chan_q     <= chan_d;
      locked_q   <= locked_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      sync_err_q <= sync_err_d;
    end
  end

  // slot_q is zero whenever the FSM is outside DATA.
  assign bus.sel      = slot_q;
  assign bus.a        = chan_q[0];
  assign bus.b        = chan_q[1];
  assign bus.c        = chan_q[2];
  assign bus.d        = chan_q[3];
  assign bus.valid    = valid_q;
  assign bus.locked   = locked_q;
  assign bus.par_err  = par_err_q;
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: frame-position model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_tdm_demux4;

  localparam bit [3:0] SW = 4'b1110;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   cmp_on;

  tdm_demux4_if bus ();

  tdm_demux4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position within the frame (-1 while hunting), recent bits while hunting.
  bit       hq[$];
  int       m_pos;
  bit       m_lock;
  bit [3:0] m_sh;
  bit [3:0] m_out;
  bit       m_val, m_pe, m_se;

  task automatic model_reset();
    hq.delete();
    m_pos  = -1;
    m_lock = 0;
    m_sh   = '0;
    m_out  = '0;
    m_val  = 0;
    m_pe   = 0;
    m_se   = 0;
  endtask

  task automatic model(input bit e, input bit d);
    m_val = 0;
    m_pe  = 0;
    m_se  = 0;
    if (!e) return;
    if (m_pos < 0) begin
      hq.push_back(d);
      if (hq.size() > 4) void'(hq.pop_front());
      if (hq.size() == 4 && {hq[0], hq[1], hq[2], hq[3]} == SW) begin
        m_pos = 4;
        hq.delete();
      end
    end else if (m_pos < 4) begin
      if (d != SW[3-m_pos]) begin
        m_se   = 1;
        m_lock = 0;
        m_pos  = -1;
      end else begin
        m_pos++;
      end
    end else if (m_pos < 8) begin
      m_sh[m_pos-4] = d;
      m_pos++;
    end else begin
      if ((m_sh[0] ^ m_sh[1] ^ m_sh[2] ^ m_sh[3] ^ d) == 1'b0) begin
        m_out  = m_sh;
        m_val  = 1;
        m_lock = 1;
        m_pos  = 0;
      end else begin
        m_pe   = 1;
        m_lock = 0;
        m_pos  = -1;
      end
    end
  endtask

  function automatic logic [9:0] exp_vec();
    logic [1:0] s;
    s = (m_pos >= 4 && m_pos < 8) ? 2'(m_pos - 4) : 2'd0;
    return {m_out[0], m_out[1], m_out[2], m_out[3], s, m_val, m_lock, m_pe, m_se};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.a, bus.b, bus.c, bus.d, bus.sel, bus.valid, bus.locked, bus.par_err,
            bus.sync_err};
  endfunction

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t abcd_sel_v_l_pe_se got=%b want=%b",
                 $time, dut_vec(), exp_vec());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic step(input bit e, input bit d);
    bus.en  = e;
    bus.din = d;
    model(e, d);
    @(negedge clk);
    #1;
  endtask

  logic [1:0] sel_log[9];
  logic       val_log[9];

  task automatic send_frame(input bit [8:0] f, input bit gapped);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, f[8-i]);
      sel_log[i] = bus.sel;
      val_log[i] = bus.valid;
      if (gapped && i < 8) begin
        step(1'b0, 1'($urandom_range(0, 1)));
        check("gap_no_pulse", {bus.valid, bus.par_err, bus.sync_err}, 3'b000);
        step(1'b0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  localparam bit [8:0] F1   = 9'b1110_1011_1;
  localparam bit [8:0] F2   = 9'b1110_0100_1;
  localparam bit [8:0] FBAD = 9'b1110_1011_0;

  initial begin
    tests   = 0;
    fails   = 0;
    cmp_on  = 0;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.din = 1'b0;
    model_reset();
    #12;
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp_on = 1;

    // Single frame, continuous en.
    send_frame(F1, 1'b0);
    check("f1_valid_9th", 32'(val_log[8]), 32'd1);
    check("f1_no_early_valid", 32'(val_log[7]), 32'd0);
    check("f1_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'b1011);
    check("f1_locked", 32'(bus.locked), 32'd1);
    check("f1_sel_after_a", 32'(sel_log[4]), 32'd1);
    check("f1_sel_after_c", 32'(sel_log[6]), 32'd3);
    check("f1_sel_parity", 32'(sel_log[7]), 32'd0);

    // Back-to-back frame.
    send_frame(F2, 1'b0);
    check("f2_valid", 32'(val_log[8]), 32'd1);
    check("f2_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'b0100);
    check("f2_locked", 32'(bus.locked), 32'd1);

    // Parity failure keeps channels, drops lock; recovery from HUNT.
    send_frame(FBAD, 1'b0);
    check("bad_par_err", 32'(bus.par_err), 32'd1);
    check("bad_no_valid", 32'(val_log[8]), 32'd0);
    check("bad_abcd_kept", 32'({bus.a, bus.b, bus.c, bus.d}), 32'b0100);
    check("bad_unlocked", 32'(bus.locked), 32'd0);
    send_frame(F1, 1'b0);
    check("recover_valid", 32'(val_log[8]), 32'd1);
    check("recover_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'b1011);

    // Broken header while locked: 1,1,0.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("hdr_ok_so_far", 32'({bus.locked, bus.sync_err}), 32'b10);
    step(1'b1, 1'b0);
    check("sync_err_3rd", 32'(bus.sync_err), 32'd1);
    check("sync_unlocked", 32'(bus.locked), 32'd0);
    send_frame(F2, 1'b0);
    check("after_sync_valid", 32'(val_log[8]), 32'd1);
    check("after_sync_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'b0100);

    // Gapped en gives the same result.
    send_frame(F1, 1'b1);
    check("gap_valid", 32'(val_log[8]), 32'd1);
    check("gap_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'b1011);
    step(1'b0, 1'b1);
    check("gap_pulse_cleared", 32'(bus.valid), 32'd0);

    // Asynchronous reset after the 6th bit of a frame.
    for (int i = 0; i < 6; i++) step(1'b1, F2[8-i]);
    cmp_on = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_zero", 32'(dut_vec()), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp_on = 1;
    for (int i = 6; i < 9; i++) step(1'b1, F2[8-i]);
    check("partial_no_valid", 32'({bus.valid, bus.locked}), 32'd0);
    send_frame(F1, 1'b0);
    check("post_reset_valid", 32'(val_log[8]), 32'd1);
    check("post_reset_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'b1011);

    step(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
